// File: rtl/l2_burst_adapter_pkg.sv
// Shared L2 cache definitions: line/beat geometry and the burst adapter state encoding.
package l2_burst_adapter_pkg;

  localparam int s_line  = 256;
  localparam int s_burst = 64;
  localparam int beats   = s_line / s_burst;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } l2_state_e;

endpackage

// File: rtl/l2_burst_adapter.sv
// Converts single-line L2 fill/writeback requests into s_line/s_burst memory beats.
// L2 holds l2_read/l2_write until the one-cycle l2_resp; memory moves one beat on
// every cycle pmem_resp is high while pmem_read/pmem_write is asserted.
module l2_burst_adapter #(
  parameter int s_line  = l2_burst_adapter_pkg::s_line,
  parameter int s_burst = l2_burst_adapter_pkg::s_burst
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            l2_read,
  input  logic                            l2_write,
  input  logic [31:0]                     l2_address,
  input  logic [s_line-1:0]               line_i,
  output logic [s_line-1:0]               line_o,
  output logic                            l2_resp,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [31:0]                     pmem_address,
  input  logic [s_burst-1:0]              pmem_rdata,
  output logic [s_burst-1:0]              pmem_wdata,
  input  logic                            pmem_resp,
  output l2_burst_adapter_pkg::l2_state_e dbg_state,
  output logic [((s_line / s_burst) > 1 ? $clog2(s_line / s_burst) : 1)-1:0] dbg_cnt
);
  import l2_burst_adapter_pkg::*;

  localparam int n_beats = s_line / s_burst;
  localparam int cnt_w   = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

  l2_state_e         state;
  l2_state_e         state_nxt;
  logic [cnt_w-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [s_line-1:0] wr_line;
  logic [s_line-1:0] rd_line;
  logic              beat_done;
  logic              last_hit;
  logic              unused_addr_bits;

  // Line addresses are 32-byte aligned, so the byte offset never reaches memory.
  assign unused_addr_bits = ^l2_address[4:0];

  assign beat_done = pmem_resp && (state == ST_READ || state == ST_WRITE);
  assign last_hit  = beat_done && (cnt == last_beat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (l2_write) begin
          state_nxt = ST_WRITE;
        end else if (l2_read) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (last_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    l2_resp    = 1'b0;
    case (state)
      ST_READ:  pmem_read  = 1'b1;
      ST_WRITE: pmem_write = 1'b1;
      ST_DONE:  l2_resp    = 1'b1;
      default: ;
    endcase
  end

  // Separate write and fill buffers keep line_o stable across writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wr_line <= '0;
      rd_line <= '0;
    end else begin
      if (state == ST_IDLE && (l2_write || l2_read)) begin
        addr_q <= {l2_address[31:5], 5'b0};
        cnt    <= '0;
        if (l2_write) begin
          wr_line <= line_i;
        end
      end
      if (beat_done) begin
        if (state == ST_READ) begin
          rd_line[s_burst*cnt +: s_burst] <= pmem_rdata;
        end
        cnt <= last_hit ? '0 : cnt + 1'b1;
      end
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wr_line[s_burst*cnt +: s_burst];
  assign line_o       = rd_line;
  assign dbg_state    = state;
  assign dbg_cnt      = cnt;

endmodule

// File: tb/tb_l2_burst_adapter.sv
// Bench for l2_burst_adapter: table of fill/writeback transactions plus reset and spurious-response sequences.
module tb_l2_burst_adapter;
  import l2_burst_adapter_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [31:0]  l2_address = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         l2_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_rdata = '0;
  logic [63:0]  pmem_wdata;
  logic         pmem_resp = 1'b0;
  l2_state_e    dbg_state;
  logic [1:0]   dbg_cnt;

  l2_burst_adapter dut (
    .clk(clk), .rst(rst), .l2_read(l2_read), .l2_write(l2_write),
    .l2_address(l2_address), .line_i(line_i), .line_o(line_o), .l2_resp(l2_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    int           stall;     // 0 none, 1 toggle from 1, 2 random, 3 toggle from 0
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t         vecs[6];
  int           total = 0;
  int           bad = 0;
  logic [255:0] exp_q[$];
  logic [63:0]  wexp_q[$];
  logic [255:0] last_line = '0;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
    chk({tag, "_cnt"}, dbg_cnt, 0);
    chk({tag, "_line_o"}, line_o, last_line);
  endtask

  // driver + scoreboard for one transaction, starting with the DUT in IDLE
  task automatic do_txn(input vec_t v);
    int   bcnt = 0;
    int   last_resp = -1;
    logic resp;
    logic done = 1'b0;
    l2_read    = v.rd;
    l2_write   = v.wr;
    l2_address = v.addr;
    line_i     = v.wline;
    if (v.wr) begin
      for (int i = 0; i < 4; i++) wexp_q.push_back(v.wline[64*i +: 64]);
    end else begin
      exp_q.push_back(v.rline);
    end
    tick();
    for (int c = 1; c <= 100 && !done; c++) begin
      if (l2_resp) begin
        chk("resp_latency", c, last_resp + 1);
        if (v.stall == 0) chk("resp_cycle5", c, 5);
        chk("beats_at_resp", bcnt, 4);
        chk("busy_in_done", {pmem_read, pmem_write}, 2'b00);
        if (!v.wr) begin
          if (exp_q.size() > 0) chk("line_o", line_o, exp_q.pop_front());
          last_line = v.rline;
        end
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        pmem_resp  = 1'b1;            // spurious response while in DONE
        pmem_rdata = {$urandom, $urandom};
        done = 1'b1;
      end else begin
        chk("req_kind", {pmem_read, pmem_write}, {~v.wr, v.wr});
        chk("pmem_address", pmem_address, v.exp_addr);
        case (v.stall)
          0:       resp = 1'b1;
          1:       resp = (c % 2) == 1;
          2:       resp = 1'($urandom_range(0, 1));
          default: resp = (c % 2) == 0;
        endcase
        if (bcnt >= 4) resp = 1'b0;
        if (v.wr && wexp_q.size() > 0) chk("pmem_wdata", pmem_wdata, wexp_q[0]);
        pmem_resp  = resp;
        pmem_rdata = resp ? v.rline[64*bcnt +: 64] : {$urandom, $urandom};
        if (resp) begin
          last_resp = c;
          bcnt++;
          if (v.wr && wexp_q.size() > 0) void'(wexp_q.pop_front());
        end
      end
      tick();
    end
    if (!done) begin
      chk("txn_timeout", 0, 1);
      l2_read  = 1'b0;
      l2_write = 1'b0;
      exp_q.delete();
      wexp_q.delete();
    end
    pmem_resp = 1'b0;
    chk("resp_one_cycle", l2_resp, 1'b0);
    chk("addr_hold", pmem_address, v.exp_addr);
    chk_idle("after_done");
  endtask

  initial begin
    logic [31:0] a;
    vec_t        rv;

    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1234_5678, wline: '0,
                rline: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                stall: 0, exp_addr: 32'h1234_5660};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'hDEAD_BEEF,
                wline: {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}},
                rline: '0, stall: 1, exp_addr: 32'hDEAD_BEE0};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_003F, wline: rand256(),
                rline: rand256(), stall: 0, exp_addr: 32'h0000_0020};
    a = $urandom;
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: a, wline: '0, rline: rand256(),
                stall: 2, exp_addr: a & 32'hFFFF_FFE0};
    a = $urandom;
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: a, wline: rand256(), rline: '0,
                stall: 3, exp_addr: a & 32'hFFFF_FFE0};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF, wline: '0,
                rline: rand256(), stall: 3, exp_addr: 32'hFFFF_FFE0};

    // asynchronous reset with no clock edge involved
    #1 rst = 1'b0;
    #2;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cnt", dbg_cnt, 0);
    chk("rst_line_o", line_o, 0);
    chk("rst_outs", {l2_resp, pmem_read, pmem_write}, 3'b000);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // spurious responses while idle
    pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pmem_rdata = {$urandom, $urandom};
      tick();
      chk_idle("spur_idle0");
    end
    pmem_resp = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pmem_rdata = {$urandom, $urandom};
      tick();
      chk_idle("spur_idle1");
    end
    pmem_resp = 1'b0;

    // reset after two beats of a read
    l2_read    = 1'b1;
    l2_address = 32'h0BAD_F00D;
    tick();
    for (int i = 0; i < 2; i++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      tick();
    end
    chk("mid_cnt", dbg_cnt, 2);
    chk("mid_read", pmem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_outs", {l2_resp, pmem_read, pmem_write}, 3'b000);
    chk("arst_addr", pmem_address, 0);
    chk("arst_wdata", pmem_wdata, 0);
    chk("arst_line_o", line_o, 0);
    chk("arst_state", dbg_state, ST_IDLE);
    l2_read   = 1'b0;
    pmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_resp", l2_resp, 1'b0);
    end
    rst = 1'b1;
    last_line = '0;
    tick();
    rv = '{rd: 1'b1, wr: 1'b0, addr: 32'h0BAD_F00D, wline: '0, rline: rand256(),
           stall: 0, exp_addr: 32'h0BAD_F000};
    do_txn(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
